// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
//   Single-clock FIFO between the UART byte engines and the host bus.
//   Provides an occupancy count, almost-full/almost-empty thresholds, a
//   read-valid strobe and sticky overflow/underflow error flags.
//
//   Build option: define FIFO_FWFT_EN for first-word-fall-through operation
//   (data_out shows the head entry while not empty, rd_en pops it).
//   Without it, reads have one cycle of registered latency.
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous reset, active-high; discards all contents
//   wr_en/data_in write request and data (ignored while full)
//   rd_en         read request (standard) or pop/acknowledge (FWFT)
//   data_out      read data
//   rd_valid      data_out carries newly read data (FWFT: !empty)
//   full/empty    level == DEPTH / level == 0
//   almost_full   level >= AF_THRESH
//   almost_empty  level <= AE_THRESH
//   level         current occupancy, 0..DEPTH
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
//   clr_err       clears both sticky flags (a new error the same cycle wins)
// -----------------------------------------------------------------------------
module sync_fifo_flags #(
    parameter int D_W       = 8,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [D_W-1:0]           data_in,
    input  logic                     rd_en,
    output logic [D_W-1:0]           data_out,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

    logic [D_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [LW-1:0]  r_level;
    logic           r_overflow;
    logic           r_underflow;

    logic           w_full;
    logic           w_empty;
    logic           w_wr_acc;
    logic           w_rd_acc;

    // All flags come from the registered level only; a read in the same
    // cycle does not open room for a write into a full FIFO.
    assign w_full   = (r_level == DEPTH_L);
    assign w_empty  = (r_level == '0);
    assign w_wr_acc = wr_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;

    // Storage has no reset so it can map onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers are exactly AW bits wide, so DEPTH-1 -> 0 wraps for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky error flags: setting has priority over clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head entry is presented directly; it appears the cycle after a write
    // into an empty FIFO because empty is decoded from the registered level.
    assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
    assign rd_valid = !w_empty;
`else
    logic [D_W-1:0] r_data_out;
    logic           r_rd_valid;

    // Registered read port: data_out holds until the next accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;
`endif

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_level >= AF_L);
    assign almost_empty = (r_level <= AE_L);
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
